ram_fifo_ctl: RTL and testbench



---
 rtl/ram_fifo_ctl.sv | 190 +++++++++++++++++++
 tb/tb_ram_fifo_ctl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctl.sv
// ram_fifo_ctl
// Single-clock FIFO controller that turns one dual-port `ram` into a FIFO.
// RAM port A is the write end and port B is the read end. The controller owns
// the write/read pointers, the occupancy count, the registered status flags,
// the sticky error flags and the one-stage read-data pipeline. It generates
// every active-low RAM strobe.
//
// Ports:
//   CLK, RST            clock (also clocks the RAM), async active-high reset
//   FLUSH               synchronous clear of all FIFO state
//   PUSH, DIN           write request and data
//   POP                 read request
//   DOUT, DOUT_VALID    registered read data and its valid strobe
//   FULL, EMPTY         registered occupancy flags
//   ALMOST_FULL/_EMPTY  registered threshold flags
//   LEVEL               words stored, 0..DEPTH
//   OVERRUN, UNDERRUN   sticky error flags, cleared by RST or FLUSH
//   AA, CENA, WENA, WENBA, DA   RAM port A (write end)
//   AB, CENB, WENB, WENBB, DB   RAM port B (read end, never writes)
//   QB                  RAM port B read data

module ram_fifo_ctl #(
   parameter int ADDRWID = 8,
   parameter int DEPTH   = 1 << ADDRWID,
   parameter int AF_GAP  = 4,
   parameter int AE_GAP  = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               FLUSH,
   input  logic               PUSH,
   input  logic [17:0]        DIN,
   input  logic               POP,
   output logic [17:0]        DOUT,
   output logic               DOUT_VALID,
   output logic               FULL,
   output logic               EMPTY,
   output logic               ALMOST_FULL,
   output logic               ALMOST_EMPTY,
   output logic [ADDRWID:0]   LEVEL,
   output logic               OVERRUN,
   output logic               UNDERRUN,
   output logic [ADDRWID-1:0] AA,
   output logic [ADDRWID-1:0] AB,
   output logic               CENA,
   output logic               WENA,
   output logic [1:0]         WENBA,
   output logic [17:0]        DA,
   output logic               CENB,
   output logic               WENB,
   output logic [1:0]         WENBB,
   output logic [17:0]        DB,
   input  logic [17:0]        QB
);

   localparam int LW = ADDRWID + 1;
   localparam logic [ADDRWID:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [ADDRWID:0] AF_LEVEL   = LW'(DEPTH - AF_GAP);
   localparam logic [ADDRWID:0] AE_LEVEL   = LW'(AE_GAP);

   logic [ADDRWID-1:0] wptr_q, wptr_d;
   logic [ADDRWID-1:0] rptr_q, rptr_d;
   logic [ADDRWID:0]   level_q, level_d;
   logic               full_q, full_d;
   logic               empty_q, empty_d;
   logic               afull_q, afull_d;
   logic               aempty_q, aempty_d;
   logic               overrun_q, overrun_d;
   logic               underrun_q, underrun_d;
   logic               rd_pend_q, rd_pend_d;
   logic               dout_valid_q, dout_valid_d;
   logic [17:0]        dout_q, dout_d;
   logic               push_ok;
   logic               pop_ok;

   // Acceptance terms. RST is folded in so the RAM sees no access while the
   // controller is being reset, even though RST is otherwise asynchronous.
   always_comb begin
      push_ok = PUSH & ~full_q  & ~FLUSH & ~RST;
      pop_ok  = POP  & ~empty_q & ~FLUSH & ~RST;
   end

   // Next-state logic for pointers, occupancy, flags and the read pipeline.
   // A rejected request only counts as an error when the opposite request was
   // not accepted in the same cycle: a push/pop pair at a boundary keeps the
   // stream balanced and is not an overrun or underrun.
   always_comb begin
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      level_d      = level_q;
      overrun_d    = overrun_q;
      underrun_d   = underrun_q;
      rd_pend_d    = 1'b0;
      dout_valid_d = 1'b0;
      dout_d       = dout_q;

      if (FLUSH) begin
         wptr_d     = '0;
         rptr_d     = '0;
         level_d    = '0;
         overrun_d  = 1'b0;
         underrun_d = 1'b0;
      end else begin
         if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
         end
         if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
         if (PUSH & full_q & ~pop_ok) begin
            overrun_d = 1'b1;
         end
         if (POP & empty_q & ~push_ok) begin
            underrun_d = 1'b1;
         end
         // The RAM registered AB at the accepting edge, so QB is valid for
         // exactly one cycle and is captured at the following edge.
         rd_pend_d    = pop_ok;
         dout_valid_d = rd_pend_q;
         if (rd_pend_q) begin
            dout_d = QB;
         end
      end

      full_d   = (level_d == FULL_LEVEL);
      empty_d  = (level_d == '0);
      afull_d  = (level_d >= AF_LEVEL);
      aempty_d = (level_d <= AE_LEVEL);
   end

   // State registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         level_q      <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         afull_q      <= 1'b0;
         aempty_q     <= 1'b1;
         overrun_q    <= 1'b0;
         underrun_q   <= 1'b0;
         rd_pend_q    <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         level_q      <= level_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         afull_q      <= afull_d;
         aempty_q     <= aempty_d;
         overrun_q    <= overrun_d;
         underrun_q   <= underrun_d;
         rd_pend_q    <= rd_pend_d;
         dout_valid_q <= dout_valid_d;
         dout_q       <= dout_d;
      end
   end

   // Output and RAM strobe mapping. Port B is tied off as read-only.
   always_comb begin
      DOUT         = dout_q;
      DOUT_VALID   = dout_valid_q;
      FULL         = full_q;
      EMPTY        = empty_q;
      ALMOST_FULL  = afull_q;
      ALMOST_EMPTY = aempty_q;
      LEVEL        = level_q;
      OVERRUN      = overrun_q;
      UNDERRUN     = underrun_q;
      AA           = wptr_q;
      AB           = rptr_q;
      CENA         = ~push_ok;
      WENA         = ~push_ok;
      WENBA        = 2'b00;
      DA           = DIN;
      CENB         = ~pop_ok;
      WENB         = 1'b1;
      WENBB        = 2'b11;
      DB           = '0;
   end

endmodule

// File: tb/tb_ram_fifo_ctl.sv
// tb_ram_fifo_ctl
// Self-checking bench for ram_fifo_ctl. A behavioural RAM is attached to the
// controller's strobes, and a queue-based reference model predicts every
// registered output each cycle and the RAM strobes before each edge. A table
// of hand-computed vectors covers the basic push/pop sequence, and directed
// sequences cover fill-to-full, wrap-around and asynchronous reset.

module tb_ram_fifo_ctl;

   localparam int ADDRWID = 8;
   localparam int DEPTH   = 256;

   logic               CLK = 1'b0;
   logic               RST;
   logic               FLUSH;
   logic               PUSH;
   logic [17:0]        DIN;
   logic               POP;
   logic [17:0]        DOUT;
   logic               DOUT_VALID;
   logic               FULL;
   logic               EMPTY;
   logic               ALMOST_FULL;
   logic               ALMOST_EMPTY;
   logic [ADDRWID:0]   LEVEL;
   logic               OVERRUN;
   logic               UNDERRUN;
   logic [ADDRWID-1:0] AA;
   logic [ADDRWID-1:0] AB;
   logic               CENA;
   logic               WENA;
   logic [1:0]         WENBA;
   logic [17:0]        DA;
   logic               CENB;
   logic               WENB;
   logic [1:0]         WENBB;
   logic [17:0]        DB;
   logic [17:0]        QB = '0;

   always #5 CLK = ~CLK;

   ram_fifo_ctl #(.ADDRWID(ADDRWID), .DEPTH(DEPTH), .AF_GAP(4), .AE_GAP(4)) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .PUSH(PUSH), .DIN(DIN), .POP(POP),
      .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .FULL(FULL), .EMPTY(EMPTY),
      .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .LEVEL(LEVEL),
      .OVERRUN(OVERRUN), .UNDERRUN(UNDERRUN), .AA(AA), .AB(AB), .CENA(CENA),
      .WENA(WENA), .WENBA(WENBA), .DA(DA), .CENB(CENB), .WENB(WENB),
      .WENBB(WENBB), .DB(DB), .QB(QB)
   );

   // Behavioural synchronous RAM: port A writes, port B reads with one
   // registered cycle of latency.
   logic [17:0] mem [DEPTH];
   always @(posedge CLK) begin
      if (!CENA && !WENA) mem[AA] <= DA;
      if (!CENB) QB <= mem[AB];
   end

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state.
   logic [17:0] m_q[$];
   logic        m_pend;
   logic [17:0] m_pend_data;
   logic [17:0] m_dout;
   logic        m_dv;
   logic        m_ovr;
   logic        m_unr;
   int          m_wcount;
   int          m_rcount;

   typedef struct {
      logic        push;
      logic        pop;
      logic        flush;
      logic [17:0] din;
      int          level;
      logic        empty;
      logic        full;
      logic        dv;
      logic        ovr;
      logic        unr;
      logic [17:0] dout;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic void modelReset();
      m_q.delete();
      m_pend      = 1'b0;
      m_pend_data = '0;
      m_dout      = '0;
      m_dv        = 1'b0;
      m_ovr       = 1'b0;
      m_unr       = 1'b0;
      m_wcount    = 0;
      m_rcount    = 0;
   endfunction

   function automatic logic modelPushOk();
      return PUSH && !FLUSH && !RST && (m_q.size() < DEPTH);
   endfunction

   function automatic logic modelPopOk();
      return POP && !FLUSH && !RST && (m_q.size() > 0);
   endfunction

   // Advance the model by one clock edge using the inputs held at that edge.
   task automatic modelEdge();
      logic pok;
      logic ook;
      pok = modelPushOk();
      ook = modelPopOk();
      if (FLUSH) begin
         m_q.delete();
         m_pend   = 1'b0;
         m_dv     = 1'b0;
         m_ovr    = 1'b0;
         m_unr    = 1'b0;
         m_wcount = 0;
         m_rcount = 0;
      end else begin
         if (PUSH && !pok && !ook) m_ovr = 1'b1;
         if (POP && !ook && !pok) m_unr = 1'b1;
         m_dv = m_pend;
         if (m_pend) m_dout = m_pend_data;
         m_pend = ook;
         if (ook) begin
            m_pend_data = m_q.pop_front();
            m_rcount++;
         end
         if (pok) begin
            m_q.push_back(DIN);
            m_wcount++;
         end
      end
   endtask

   task automatic checkStrobes();
      logic pok;
      logic ook;
      pok = modelPushOk();
      ook = modelPopOk();
      chk("CENA", CENA, !pok);
      chk("WENA", WENA, !pok);
      chk("CENB", CENB, !ook);
      chk("DA", DA, DIN);
      if (pok) chk("AA", AA, m_wcount % DEPTH);
      if (ook) chk("AB", AB, m_rcount % DEPTH);
   endtask

   task automatic checkOutput();
      int sz;
      sz = m_q.size();
      chk("LEVEL", LEVEL, sz);
      chk("EMPTY", EMPTY, sz == 0);
      chk("FULL", FULL, sz == DEPTH);
      chk("ALMOST_FULL", ALMOST_FULL, sz >= DEPTH - 4);
      chk("ALMOST_EMPTY", ALMOST_EMPTY, sz <= 4);
      chk("OVERRUN", OVERRUN, m_ovr);
      chk("UNDERRUN", UNDERRUN, m_unr);
      chk("DOUT_VALID", DOUT_VALID, m_dv);
      chk("DOUT", DOUT, m_dout);
   endtask

   // Drive one cycle of inputs, check strobes before the edge, then check
   // registered outputs shortly after it.
   task automatic applyStimulus(input logic push, input logic pop, input logic flush,
                                input logic [17:0] din);
      PUSH  = push;
      POP   = pop;
      FLUSH = flush;
      DIN   = din;
      #1;
      checkStrobes();
      @(posedge CLK);
      modelEdge();
      #1;
      checkOutput();
   endtask

   initial begin
      // Hand-computed vectors: five pushes, five pops, push/pop at empty,
      // pop on empty, flush.
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 18'h00001, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 18'h00002, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 18'h00003, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 18'h00004, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 18'h00005, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h2};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h3};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 18'h4};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 18'h00000, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 18'h5};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 18'h00000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'h5};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 18'h00AAA, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h5};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 18'h00000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'h5};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 18'h00000, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 18'hAAA};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 18'h00000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'hAAA};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 18'h00000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'hAAA};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 18'h00000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'hAAA};

      RST   = 1'b1;
      FLUSH = 1'b0;
      PUSH  = 1'b0;
      POP   = 1'b0;
      DIN   = '0;
      modelReset();
      repeat (2) @(posedge CLK);
      #1;
      $display("[TB] reset state");
      checkOutput();
      chk("reset CENA", CENA, 1'b1);
      chk("reset CENB", CENB, 1'b1);
      RST = 1'b0;

      $display("[TB] vector table");
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].din);
         chk($sformatf("vec%0d LEVEL", i), LEVEL, vecs[i].level);
         chk($sformatf("vec%0d EMPTY", i), EMPTY, vecs[i].empty);
         chk($sformatf("vec%0d FULL", i), FULL, vecs[i].full);
         chk($sformatf("vec%0d DOUT_VALID", i), DOUT_VALID, vecs[i].dv);
         chk($sformatf("vec%0d OVERRUN", i), OVERRUN, vecs[i].ovr);
         chk($sformatf("vec%0d UNDERRUN", i), UNDERRUN, vecs[i].unr);
         chk($sformatf("vec%0d DOUT", i), DOUT, vecs[i].dout);
      end

      $display("[TB] fill to full");
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 18'(i + 'h100));
         if (i == DEPTH - 5) chk("AF at 252", ALMOST_FULL, 1'b1);
         if (i == DEPTH - 6) chk("AF at 251", ALMOST_FULL, 1'b0);
      end
      chk("full after 256", FULL, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 18'h3FFFF);
      chk("push while full LEVEL", LEVEL, 9'd256);
      chk("push while full OVERRUN", OVERRUN, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 18'h12345);
      chk("push+pop full LEVEL", LEVEL, 9'd255);
      chk("push+pop full FULL", FULL, 1'b0);
      for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
      chk("flush OVERRUN", OVERRUN, 1'b0);

      $display("[TB] wrap-around");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 18'(i));
      for (int i = 3; i < 303; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 18'(i));
         if (i >= 5) begin
            chk("wrap DOUT_VALID", DOUT_VALID, 1'b1);
            chk("wrap DOUT", DOUT, 18'(i - 4));
         end
      end
      chk("wrap LEVEL", LEVEL, 9'd3);

      $display("[TB] random traffic");
      for (int i = 0; i < 1200; i++) begin
         logic rp;
         logic rq;
         logic rf;
         if (i < 600) begin
            rp = ($urandom_range(0, 99) < 75);
            rq = ($urandom_range(0, 99) < 35);
         end else begin
            rp = ($urandom_range(0, 99) < 35);
            rq = ($urandom_range(0, 99) < 75);
         end
         rf = ($urandom_range(0, 199) == 0);
         applyStimulus(rp, rq, rf, 18'($urandom));
      end
      applyStimulus(1'b0, 1'b0, 1'b1, '0);

      $display("[TB] async reset mid-read");
      applyStimulus(1'b1, 1'b0, 1'b0, 18'h0BEEF);
      applyStimulus(1'b1, 1'b0, 1'b0, 18'h0CAFE);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      PUSH = 1'b0;
      POP  = 1'b0;
      #2;
      RST  = 1'b1;
      PUSH = 1'b1;
      POP  = 1'b1;
      #1;
      modelReset();
      checkOutput();
      chk("rst CENA", CENA, 1'b1);
      chk("rst WENA", WENA, 1'b1);
      chk("rst CENB", CENB, 1'b1);
      #1;
      RST  = 1'b0;
      PUSH = 1'b0;
      POP  = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      chk("no DOUT_VALID after rst", DOUT_VALID, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 18'h01234);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      chk("fresh DOUT_VALID", DOUT_VALID, 1'b1);
      chk("fresh DOUT", DOUT, 18'h01234);

      $display("[TB] %0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
